// File: rtl/mul_sched_pkg.sv
// Shared types and constants for the multiplier cell scheduler.
package mul_sched_pkg;

    localparam int MUL_W    = 32;
    // Widest requester index (NUM_REQ up to 8); entries carry this many id bits.
    localparam int ID_MAX_W = 3;

    // Requester index width: $clog2 with a floor of one bit.
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [ID_MAX_W-1:0] id;
        logic [MUL_W-1:0]    result;
    } rsp_entry_t;

endpackage

// File: rtl/mul_result_fifo.sv
// First-word-fall-through result FIFO. The head entry is presented on rd_data
// whenever the FIFO is non-empty. A read and a write in the same cycle are
// accepted even when full, since the read frees the slot being written.
module mul_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             wr_ok, rd_ok;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rd_ok   = rd_en && !empty;
    assign wr_ok   = wr_en && (!full || rd_ok);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array: no reset needed, reads are masked while empty.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_ptr] <= wr_data;
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (rd_ok) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mul_cell_sched.sv
// Round-robin scheduler sharing one pipelined multiplier cell between several
// requesters. Operands are registered into the cell, the requester id rides a
// tag pipe alongside the cell, and results park in a FWFT FIFO so the consumer
// can back-pressure a pipeline that itself never stalls. Issue is gated by a
// credit count so every in-flight result is guaranteed a FIFO slot.
module mul_cell_sched
    import mul_sched_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int MUL_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4,
    localparam int ID_W  = id_w(NUM_REQ),
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [MUL_W*NUM_REQ-1:0] req_src1,
    input  logic [MUL_W*NUM_REQ-1:0] req_src2,
    output logic [MUL_W-1:0]         mul_src1,
    output logic [MUL_W-1:0]         mul_src2,
    input  logic [MUL_W-1:0]         mul_result,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [MUL_W-1:0]         rsp_result,
    input  logic                     rsp_ready
);

    logic [ID_W-1:0]                  rr_ptr, gnt_id, cand;
    logic                             gnt_found, have_space, issue;
    logic [MUL_LATENCY:0]             vld_pipe;
    logic [MUL_LATENCY:0][ID_W-1:0]   id_pipe;
    logic                             last_vld;
    logic [CNT_W-1:0]                 inflight, fifo_count;
    logic [CNT_W:0]                   used;
    logic                             fifo_full, fifo_empty, fifo_rd;
    rsp_entry_t                       wr_entry, rd_entry;

    // Credit: a slot is reserved at issue, so a same-cycle dequeue is not counted.
    assign used       = {1'b0, fifo_count} + {1'b0, inflight};
    assign have_space = used < (CNT_W+1)'(FIFO_DEPTH);
    assign last_vld   = vld_pipe[MUL_LATENCY];
    assign fifo_rd    = rsp_ready && !fifo_empty;

    // Arbiter: first valid requester after the rr pointer, wrapping.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    // One-hot ready; held low during reset so nothing transfers while flops are cleared.
    always_comb begin
        req_ready = '0;
        issue     = gnt_found && have_space && reset_n;
        if (issue) req_ready[gnt_id] = 1'b1;
    end

    // Operand registers and round-robin pointer, updated only on a transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mul_src1 <= '0;
            mul_src2 <= '0;
            rr_ptr   <= ID_W'(NUM_REQ - 1);
        end else if (issue) begin
            mul_src1 <= req_src1[MUL_W*gnt_id +: MUL_W];
            mul_src2 <= req_src2[MUL_W*gnt_id +: MUL_W];
            rr_ptr   <= gnt_id;
        end
    end

    // Tag pipe: follows the cell so the last stage lines up with a valid mul_result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
        end else begin
            vld_pipe[0] <= issue;
            id_pipe[0]  <= gnt_id;
            for (int s = 1; s <= MUL_LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    // In-flight count: up on issue, down when a result lands in the FIFO.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight <= '0;
        end else begin
            case ({issue, last_vld})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: ;
            endcase
        end
    end

    assign wr_entry = '{id: ID_MAX_W'(id_pipe[MUL_LATENCY]), result: mul_result};

    mul_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(rsp_entry_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (last_vld),
        .wr_data (wr_entry),
        .rd_en   (fifo_rd),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign rsp_valid  = !fifo_empty;
    assign rsp_id     = ID_W'(rd_entry.id);
    assign rsp_result = rd_entry.result;

    // The credit scheme must never let a result arrive at a full FIFO.
    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(last_vld && fifo_full && !fifo_rd));

endmodule

// File: tb/tb_mul_cell_sched.sv
// Bench for mul_cell_sched: directed cases plus random traffic against a
// transaction-level scoreboard (grant order, credit limit, products, latency).
module tb_mul_cell_sched;

    localparam int NUM_REQ     = 2;
    localparam int MUL_LATENCY = 1;
    localparam int FIFO_DEPTH  = 4;
    localparam int ID_W        = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    logic                    clk = 1'b0;
    logic                    reset_n = 1'b0;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic [32*NUM_REQ-1:0]   req_src1 = '0, req_src2 = '0;
    logic [31:0]             mul_src1, mul_src2, mul_result;
    logic                    rsp_valid;
    logic [ID_W-1:0]         rsp_id;
    logic [31:0]             rsp_result;
    logic                    rsp_ready = 1'b0;

    always #5 clk = ~clk;

    mul_cell_sched #(
        .NUM_REQ(NUM_REQ), .MUL_LATENCY(MUL_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src1(req_src1), .req_src2(req_src2),
        .mul_src1(mul_src1), .mul_src2(mul_src2), .mul_result(mul_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_ready(rsp_ready)
    );

    // Multiplier cell: MUL_LATENCY register stages on the low product word.
    logic [31:0] cell_q [MUL_LATENCY];
    always @(posedge clk) begin
        cell_q[0] <= mul_src1 * mul_src2;
        for (int s = 1; s < MUL_LATENCY; s++) cell_q[s] <= cell_q[s-1];
    end
    assign mul_result = cell_q[MUL_LATENCY-1];

    int total = 0, bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: every accepted op owns a slot until consumed; it becomes
    // visible MUL_LATENCY+1 edges after its accept edge, in accept order.
    typedef struct {
        int          id;
        logic [31:0] res;
        longint      avail;
    } exp_t;
    exp_t   sb[$];
    int     gnt_log[$];
    longint cyc = 0;
    int     last_gnt = NUM_REQ - 1;
    int     n_acc = 0, n_rsp = 0;
    logic [NUM_REQ-1:0] er;
    bit     ev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [NUM_REQ-1:0] exp_ready(input logic [NUM_REQ-1:0] v,
                                                     input int last, input int outstanding);
        logic [NUM_REQ-1:0] r;
        r = '0;
        if (outstanding < FIFO_DEPTH) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                int j;
                j = (last + k) % NUM_REQ;
                if (v[j]) begin
                    r[j] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_req_ready", req_ready, '0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_result", rsp_result, 0);
            chk("rst_mul_src", {mul_src1, mul_src2}, 0);
            sb.delete();
            last_gnt = NUM_REQ - 1;
        end else begin
            er = exp_ready(req_valid, last_gnt, sb.size());
            chk("req_ready", req_ready, er);
            ev = (sb.size() > 0) && (sb[0].avail <= cyc);
            chk("rsp_valid", rsp_valid, ev);
            if (rsp_valid && ev) begin
                chk("rsp_id", rsp_id, sb[0].id);
                chk("rsp_result", rsp_result, sb[0].res);
            end
            if (rsp_valid && rsp_ready && sb.size() > 0) begin
                void'(sb.pop_front());
                n_rsp++;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    sb.push_back('{id: i,
                                   res: req_src1[32*i +: 32] * req_src2[32*i +: 32],
                                   avail: cyc + MUL_LATENCY + 2});
                    last_gnt = i;
                    n_acc++;
                    gnt_log.push_back(i);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 50) begin
            tick();
            n++;
        end
    endtask

    // Single op on an idle scheduler; reports edges to rsp_valid after transfer.
    task automatic one_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_src1[32*id +: 32] = a;
        req_src2[32*id +: 32] = b;
        tick();
        req_valid = '0;
        wait_rsp(lat);
    endtask

    initial begin
        int n, acc0, cnt, stale;
        repeat (3) tick();
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        tick();

        // Single op: 3 x 5
        one_op(0, 32'd3, 32'd5, n);
        chk("t1_latency", n, MUL_LATENCY + 1);
        chk("t1_id", rsp_id, 0);
        chk("t1_result", rsp_result, 15);
        repeat (3) tick();

        // Both requesters continuously valid: alternating grants, one result per cycle
        gnt_log.delete();
        acc0 = n_acc;
        cnt = 0;
        req_valid = '1;
        for (int c = 1; c <= 8; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                req_src1[32*i +: 32] = $urandom;
                req_src2[32*i +: 32] = $urandom;
            end
            tick();
            if (c >= 3 && rsp_valid) cnt++;
        end
        req_valid = '0;
        chk("t2_accepted", n_acc - acc0, 8);
        chk("t2_rsp_per_cycle", cnt, 6);
        if (gnt_log.size() > 0) chk("t2_first_grant", gnt_log[0], 1);
        for (int i = 1; i < gnt_log.size(); i++)
            chk("t2_alternate", gnt_log[i], (gnt_log[i-1] + 1) % NUM_REQ);
        repeat (6) tick();

        // Modulo-2^32 products
        one_op(0, 32'hFFFF_FFFF, 32'h2, n);
        chk("t3_wrap_a", rsp_result, 32'hFFFF_FFFE);
        tick();
        one_op(1, 32'h0001_0000, 32'h0001_0000, n);
        chk("t3_wrap_b_id", rsp_id, 1);
        chk("t3_wrap_b", rsp_result, 32'h0);
        repeat (3) tick();

        // Back-pressure: exactly FIFO_DEPTH accepted, then ready drops; in-order drain
        rsp_ready = 1'b0;
        acc0 = n_acc;
        req_valid = '1;
        repeat (10) tick();
        chk("t4_accepted", n_acc - acc0, FIFO_DEPTH);
        chk("t4_ready_low", req_ready, '0);
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 50) begin tick(); n++; end
        chk("t4_drained", sb.size(), 0);
        repeat (2) tick();

        // Reset with ops in flight and queued
        rsp_ready = 1'b0;
        acc0 = n_acc;
        req_valid = 'b1;
        repeat (3) tick();
        chk("t5_accepted", n_acc - acc0, 3);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_rsp_valid", rsp_valid, 0);
        chk("t5_rst_req_ready", req_ready, '0);
        chk("t5_rst_mul_src1", mul_src1, 0);
        chk("t5_rst_rsp_result", rsp_result, 0);
        repeat (2) tick();
        req_valid = '0;
        reset_n = 1'b1;
        rsp_ready = 1'b1;
        stale = 0;
        repeat (10) begin
            tick();
            if (rsp_valid) stale++;
        end
        chk("t5_no_stale", stale, 0);

        // Random traffic with random back-pressure
        for (int c = 0; c < 10000; c++) begin
            req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
            for (int i = 0; i < NUM_REQ; i++) begin
                req_src1[32*i +: 32] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
                req_src2[32*i +: 32] = $urandom;
            end
            rsp_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        n = 0;
        while (sb.size() > 0 && n < 100) begin tick(); n++; end
        chk("t6_drained", sb.size(), 0);
        tick();
        chk("t6_idle_rsp_valid", rsp_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
